// File: rtl/conv_layer_sequencer.sv
// Layer controller for a single conv_engine: for every (oc, ic) pair it loads a
// 5x5 kernel, starts the engine, streams one feature map and waits for done.
module conv_layer_sequencer #(
    parameter int MAPSIZE = 32,
    parameter int IN_CH   = 6,
    parameter int OUT_CH  = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic                                        hold,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    output logic [$clog2(OUT_CH*IN_CH*25)-1:0]          w_rd_addr,
    output logic                                        w_rd_en,
    input  logic signed [7:0]                           w_rd_data,
    output logic [$clog2(IN_CH*MAPSIZE*MAPSIZE)-1:0]    f_rd_addr,
    output logic                                        f_rd_en,
    input  logic signed [7:0]                           f_rd_data,
    output logic                                        eng_start,
    output logic                                        eng_valid,
    output logic signed [7:0]                           eng_pixel,
    output logic signed [4:0][4:0][7:0]                 eng_weights,
    input  logic                                        eng_done,
    output logic [$clog2(OUT_CH)-1:0]                   cur_oc,
    output logic [$clog2(IN_CH)-1:0]                    cur_ic,
    output logic                                        acc_mode
);
    localparam int MS2 = MAPSIZE * MAPSIZE;
    localparam int WA  = $clog2(OUT_CH * IN_CH * 25);
    localparam int FA  = $clog2(IN_CH * MS2);
    localparam int OCW = $clog2(OUT_CH);
    localparam int ICW = $clog2(IN_CH);
    localparam int PW  = $clog2(MS2 + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_ENG_START, S_STREAM, S_WAIT_DONE, S_NEXT, S_DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [4:0]                  k_reg;
    logic [PW-1:0]               p_reg;
    logic [OCW-1:0]              oc_reg;
    logic [ICW-1:0]              ic_reg;
    logic                        err_reg;
    logic                        valid_reg;
    logic signed [4:0][4:0][7:0] weights_reg;
    logic [24:0]                 slot_we;
    logic                        last_ic, last_pass, w_issue, f_issue;
    logic [WA-1:0]               w_base;
    logic [FA-1:0]               f_base;

    assign last_ic   = (ic_reg == ICW'(IN_CH - 1));
    assign last_pass = last_ic && (oc_reg == OCW'(OUT_CH - 1));
    assign w_issue   = (state_reg == S_LOAD_W) && (k_reg < 5'd25);
    assign f_issue   = (state_reg == S_STREAM) && !hold && (p_reg < PW'(MS2));
    assign w_base    = (WA'(oc_reg) * WA'(IN_CH) + WA'(ic_reg)) * WA'(25);
    assign f_base    = FA'(ic_reg) * FA'(MS2);

    assign w_rd_en     = w_issue;
    assign w_rd_addr   = w_issue ? (w_base + WA'(k_reg)) : '0;
    assign f_rd_en     = f_issue;
    assign f_rd_addr   = f_issue ? (f_base + FA'(p_reg)) : '0;
    assign eng_start   = (state_reg == S_ENG_START);
    assign eng_valid   = valid_reg;
    // The BRAM output register already holds the pixel in the delivery cycle;
    // gating keeps the port at zero on idle cycles and during reset.
    assign eng_pixel   = valid_reg ? f_rd_data : '0;
    assign eng_weights = weights_reg;
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign err         = err_reg;
    assign cur_oc      = oc_reg;
    assign cur_ic      = ic_reg;
    assign acc_mode    = (ic_reg != '0);

    // Kernel slot gi is written one cycle after its ROM read was issued.
    for (genvar gi = 0; gi < 25; gi++) begin : g_slot_we
        assign slot_we[gi] = (state_reg == S_LOAD_W) && (k_reg == 5'(gi + 1));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = S_LOAD_W;
            S_LOAD_W:    if (k_reg == 5'd25) state_next = S_ENG_START;
            S_ENG_START: state_next = S_STREAM;
            S_STREAM:    if (p_reg == PW'(MS2)) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (eng_done) state_next = S_NEXT;
            S_NEXT:      state_next = last_pass ? S_DONE : S_LOAD_W;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            k_reg     <= '0;
            p_reg     <= '0;
            oc_reg    <= '0;
            ic_reg    <= '0;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= f_issue;
            k_reg     <= (state_reg == S_LOAD_W) ? k_reg + 5'd1 : '0;
            if (state_reg == S_STREAM) begin
                if (f_issue) p_reg <= p_reg + PW'(1);
            end else begin
                p_reg <= '0;
            end
            if (state_reg == S_IDLE && start) begin
                oc_reg <= '0;
                ic_reg <= '0;
            end else if (state_reg == S_NEXT) begin
                if (last_ic) begin
                    ic_reg <= '0;
                    oc_reg <= oc_reg + OCW'(1);
                end else begin
                    ic_reg <= ic_reg + ICW'(1);
                end
            end
            if (state_reg == S_IDLE && start) err_reg <= 1'b0;
            else if (eng_done && state_reg != S_WAIT_DONE) err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_reg <= '0;
        end else begin
            for (int i = 0; i < 25; i++) begin
                if (slot_we[i]) weights_reg[i / 5][i % 5] <= w_rd_data;
            end
        end
    end
endmodule
